// File: rtl/a0_trace_pkg.sv
// Shared types and constants for the a0 trace streamer.
// Build option A0_TRACE_TIMESTAMP_EN widens each frame with a 32-bit cycle stamp.
package a0_trace_pkg;

    localparam int unsigned A0_WIDTH       = 32;
    localparam int unsigned BYTE_W         = 8;
    localparam int unsigned BYTES_PER_WORD = A0_WIDTH / BYTE_W;
    localparam int unsigned TS_WIDTH       = 32;

`ifdef A0_TRACE_TIMESTAMP_EN
    localparam int unsigned FRAME_BYTES = BYTES_PER_WORD + TS_WIDTH / BYTE_W;
`else
    localparam int unsigned FRAME_BYTES = BYTES_PER_WORD;
`endif

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

endpackage

// File: rtl/a0_trace_streamer_if.sv
// Valid/ready byte stream carrying serialised a0 trace frames.
interface a0_trace_streamer_if;
    import a0_trace_pkg::*;

    logic [BYTE_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;

    modport master (output out_data, output out_valid, input out_ready);
    modport slave  (input out_data, input out_valid, output out_ready);

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy and full/empty flags.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo #(
    parameter  int unsigned WIDTH = 32,
    parameter  int unsigned DEPTH = 8,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] headC,
    output logic             full,
    output logic             empty,
    output logic [LVL_W-1:0] level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wPtr;
    logic [PTR_W-1:0] rPtr;
    logic             wrEn;
    logic             rdEn;
    logic [LVL_W-1:0] levelNext;

    assign rdEn      = pop && !empty;
    assign wrEn      = push && (!full || rdEn);
    assign levelNext = level + LVL_W'(wrEn) - LVL_W'(rdEn);
    assign headC     = mem[rPtr];

    // Storage carries no reset; only pointers and flags define validity.
    always_ff @(posedge clk) begin
        if (wrEn) begin
            mem[wPtr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wPtr  <= '0;
            rPtr  <= '0;
            level <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else begin
            if (wrEn) begin
                wPtr <= wPtr + PTR_W'(1);
            end
            if (rdEn) begin
                rPtr <= rPtr + PTR_W'(1);
            end
            level <= levelNext;
            full  <= (levelNext == LVL_W'(DEPTH));
            empty <= (levelNext == '0);
        end
    end

endmodule

// File: rtl/a0_trace_streamer.sv
// Captures each new a0 value into a FIFO and streams it as little-endian bytes.
// Build option A0_TRACE_TIMESTAMP_EN prefixes every frame with a 32-bit cycle stamp.
module a0_trace_streamer
    import a0_trace_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH = A0_WIDTH,
    parameter  int unsigned DEPTH      = 8,
    localparam int unsigned LVL_W      = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] a0,
    input  logic                  capture_en,
    a0_trace_streamer_if.master   link,
    output logic                  overflow,
    output logic [LVL_W-1:0]      level
);

`ifdef A0_TRACE_TIMESTAMP_EN
    localparam int unsigned STAMP_W = TS_WIDTH;
`else
    localparam int unsigned STAMP_W = 0;
`endif
    localparam int unsigned WORD_W  = DATA_WIDTH + STAMP_W;
    localparam int unsigned FRAME_B = WORD_W / BYTE_W;
    localparam int unsigned IDX_W   = (FRAME_B > 1) ? $clog2(FRAME_B) : 1;

    logic [DATA_WIDTH-1:0] lastA0;
    logic [WORD_W-1:0]     pushWord;
    logic [WORD_W-1:0]     fifoHead;
    logic [WORD_W-1:0]     shiftWord;
    logic [WORD_W-1:0]     shiftNext;
    logic [IDX_W-1:0]      idx;
    logic [IDX_W-1:0]      idxNext;
    logic                  pushReq;
    logic                  popC;
    logic                  fifoFull;
    logic                  fifoEmpty;
    logic                  outValid;
    logic                  validNext;
    logic                  handshakeC;
    logic                  lastByteC;
    state_t                state;
    state_t                stateNext;

`ifdef A0_TRACE_TIMESTAMP_EN
    logic [TS_WIDTH-1:0] tsCount;

    // Free-running stamp; the low bytes of each frame carry it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tsCount <= '0;
        end else begin
            tsCount <= tsCount + TS_WIDTH'(1);
        end
    end

    assign pushWord = {a0, tsCount};
`else
    assign pushWord = a0;
`endif

    assign pushReq        = capture_en && (a0 != lastA0);
    assign handshakeC     = outValid && link.out_ready;
    assign lastByteC      = (idx == IDX_W'(FRAME_B - 1));
    assign link.out_valid = outValid;
    assign link.out_data  = shiftWord[BYTE_W-1:0];

    sync_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (pushReq),
        .wdata (pushWord),
        .pop   (popC),
        .headC (fifoHead),
        .full  (fifoFull),
        .empty (fifoEmpty),
        .level (level)
    );

    // lastA0 follows every detected change, even one the FIFO drops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lastA0   <= '0;
            overflow <= 1'b0;
        end else begin
            if (pushReq) begin
                lastA0 <= a0;
            end
            if (pushReq && fifoFull && !popC) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            shiftWord <= '0;
            idx       <= '0;
            outValid  <= 1'b0;
        end else begin
            state     <= stateNext;
            shiftWord <= shiftNext;
            idx       <= idxNext;
            outValid  <= validNext;
        end
    end

    // Byte 0 always sits in the low lane; the last handshake reloads without a bubble.
    always_comb begin
        stateNext = state;
        shiftNext = shiftWord;
        idxNext   = idx;
        popC      = 1'b0;
        unique case (state)
            IDLE: begin
                if (!fifoEmpty) begin
                    popC      = 1'b1;
                    shiftNext = fifoHead;
                    idxNext   = '0;
                    stateNext = SEND;
                end
            end
            SEND: begin
                if (handshakeC) begin
                    if (!lastByteC) begin
                        idxNext   = idx + IDX_W'(1);
                        shiftNext = shiftWord >> BYTE_W;
                    end else if (!fifoEmpty) begin
                        popC      = 1'b1;
                        shiftNext = fifoHead;
                        idxNext   = '0;
                    end else begin
                        shiftNext = shiftWord >> BYTE_W;
                        idxNext   = '0;
                        stateNext = IDLE;
                    end
                end
            end
            default: stateNext = IDLE;
        endcase
        validNext = (stateNext == SEND);
    end

endmodule

// File: tb/tb_a0_trace_streamer.sv
// Self-checking bench for a0_trace_streamer against a queue-based frame model.
`timescale 1ns/1ps
module tb_a0_trace_streamer;
    import a0_trace_pkg::*;

    localparam int unsigned DW  = 32;
    localparam int unsigned DEP = 8;
    localparam int unsigned LW  = $clog2(DEP) + 1;
    localparam int          NB  = FRAME_BYTES;
    localparam int          TSB = FRAME_BYTES - BYTES_PER_WORD;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [DW-1:0] a0 = '0;
    logic          capture_en = 1'b0;
    logic          overflow;
    logic [LW-1:0] level;

    a0_trace_streamer_if link ();

    a0_trace_streamer #(.DATA_WIDTH(DW), .DEPTH(DEP)) dut (
        .clk        (clk),
        .rst        (rst),
        .a0         (a0),
        .capture_en (capture_en),
        .link       (link),
        .overflow   (overflow),
        .level      (level)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: accepted frames in a queue, plus the frame currently on the wire.
    logic [8*NB-1:0] mq [$];
    logic [8*NB-1:0] mWord;
    logic [8*NB-1:0] mNew;
    logic [DW-1:0]   mLast;
    logic [31:0]     mCnt;
    int              mIdx;
    logic            mBusy;
    logic            mOvf;
    logic            mHs;
    logic            mPop;
    logic            mPush;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mq.delete();
            mWord = '0;
            mLast = '0;
            mCnt  = '0;
            mIdx  = 0;
            mBusy = 1'b0;
            mOvf  = 1'b0;
        end else begin
            mHs   = mBusy && link.out_ready;
            mPop  = (mq.size() > 0) && (!mBusy || (mHs && mIdx == NB - 1));
            mPush = capture_en && (a0 != mLast);
`ifdef A0_TRACE_TIMESTAMP_EN
            mNew  = {a0, mCnt};
`else
            mNew  = a0;
`endif
            if (mPush) mLast = a0;
            if (mPop) begin
                mWord = mq.pop_front();
                mIdx  = 0;
                mBusy = 1'b1;
            end else if (mHs) begin
                if (mIdx == NB - 1) mBusy = 1'b0;
                else mIdx = mIdx + 1;
            end
            if (mPush) begin
                if (mq.size() < DEP) mq.push_back(mNew);
                else mOvf = 1'b1;
            end
            mCnt = mCnt + 32'd1;
        end
    end

    function automatic logic [7:0] byteOf(input logic [31:0] w, input int k);
        return w[8*k +: 8];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        capture_en     = 1'b0;
        a0             = '0;
        link.out_ready = 1'b0;
        #2 rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if (link.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", link.out_valid); end
        checks++;
        if (link.out_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %0h expected 0", link.out_data); end
        checks++;
        if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %0b expected 0", overflow); end
        checks++;
        if (level !== '0) begin errors++; $display("FAIL reset_level: got %0d expected 0", level); end
        tick();
        rst = 1'b1;
        tick();
        checks++;
        if (link.out_valid !== 1'b0 || level !== '0) begin
            errors++; $display("FAIL reset_release: valid=%0b level=%0d expected 0/0", link.out_valid, level);
        end
    endtask

    task automatic test_single_frame();
        logic [7:0] expB;
        do_reset();
        capture_en     = 1'b1;
        link.out_ready = 1'b1;
        a0             = 32'h11223344;
        tick();
        checks++;
        if (link.out_valid !== 1'b0 || level !== LW'(1)) begin
            errors++; $display("FAIL latency_e0: valid=%0b level=%0d expected 0/1", link.out_valid, level);
        end
        tick();
        for (int k = 0; k < NB; k++) begin
            expB = (k < TSB) ? mWord[8*k +: 8] : byteOf(32'h11223344, k - TSB);
            checks++;
            if (link.out_valid !== 1'b1 || link.out_data !== expB) begin
                errors++; $display("FAIL frame_byte%0d: valid=%0b data=%0h expected 1/%0h", k, link.out_valid, link.out_data, expB);
            end
            tick();
        end
        checks++;
        if (link.out_valid !== 1'b0 || level !== '0) begin
            errors++; $display("FAIL frame_end: valid=%0b level=%0d expected 0/0", link.out_valid, level);
        end
    endtask

    task automatic test_hold();
        int got = 0;
        do_reset();
        capture_en     = 1'b1;
        link.out_ready = 1'b1;
        a0             = 32'h5;
        for (int c = 0; c < 24; c++) begin
            tick();
            if (link.out_valid) got++;
        end
        checks++;
        if (got != NB) begin errors++; $display("FAIL hold_bytes: got %0d expected %0d", got, NB); end
        checks++;
        if (level !== '0 || overflow !== 1'b0) begin
            errors++; $display("FAIL hold_level: level=%0d ovf=%0b expected 0/0", level, overflow);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] expB;
        do_reset();
        capture_en = 1'b1;
        for (int v = 1; v <= DEP + 2; v++) begin
            a0 = DW'(v);
            tick();
        end
        checks++;
        if (level !== LW'(DEP)) begin errors++; $display("FAIL ovf_level: got %0d expected %0d", level, DEP); end
        checks++;
        if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %0b expected 1", overflow); end
        link.out_ready = 1'b1;
        for (int j = 1; j <= DEP + 1; j++) begin
            for (int k = 0; k < NB; k++) begin
                expB = (k < TSB) ? mWord[8*k +: 8] : byteOf(32'(j), k - TSB);
                checks++;
                if (link.out_valid !== 1'b1 || link.out_data !== expB) begin
                    errors++; $display("FAIL ovf_stream_w%0d_b%0d: valid=%0b data=%0h expected 1/%0h", j, k, link.out_valid, link.out_data, expB);
                end
                tick();
            end
        end
        checks++;
        if (link.out_valid !== 1'b0 || level !== '0 || overflow !== 1'b1) begin
            errors++; $display("FAIL ovf_drain: valid=%0b level=%0d ovf=%0b expected 0/0/1", link.out_valid, level, overflow);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] rx [$];
        logic [7:0] prevData = '0;
        logic       prevStall = 1'b0;
        do_reset();
        capture_en = 1'b1;
        a0         = 32'hA1B2C3D4;
        for (int c = 0; c < 40; c++) begin
            link.out_ready = c[0];
            if (link.out_valid) begin
                checks++;
                if (link.out_data !== mWord[8*mIdx +: 8]) begin
                    errors++; $display("FAIL bp_data: got %0h expected %0h", link.out_data, mWord[8*mIdx +: 8]);
                end
                if (prevStall) begin
                    checks++;
                    if (link.out_data !== prevData) begin
                        errors++; $display("FAIL bp_hold: got %0h expected %0h", link.out_data, prevData);
                    end
                end
                if (link.out_ready) rx.push_back(link.out_data);
            end
            prevStall = link.out_valid && !link.out_ready;
            prevData  = link.out_data;
            tick();
        end
        checks++;
        if (rx.size() != NB) begin
            errors++; $display("FAIL bp_count: got %0d expected %0d", rx.size(), NB);
        end else begin
            for (int k = 0; k < BYTES_PER_WORD; k++) begin
                checks++;
                if (rx[TSB + k] !== byteOf(32'hA1B2C3D4, k)) begin
                    errors++; $display("FAIL bp_order%0d: got %0h expected %0h", k, rx[TSB + k], byteOf(32'hA1B2C3D4, k));
                end
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            capture_en     = ($urandom_range(0, 9) != 0);
            link.out_ready = ($urandom_range(0, 9) < 6);
            if ($urandom_range(0, 4) == 0) a0 = ($urandom_range(0, 1) == 0) ? DW'($urandom_range(0, 3)) : $urandom;
            tick();
            checks++;
            if (link.out_valid !== mBusy) begin
                errors++; $display("FAIL rnd_valid@%0d: got %0b expected %0b", c, link.out_valid, mBusy);
            end
            if (mBusy) begin
                checks++;
                if (link.out_data !== mWord[8*mIdx +: 8]) begin
                    errors++; $display("FAIL rnd_data@%0d: got %0h expected %0h", c, link.out_data, mWord[8*mIdx +: 8]);
                end
            end
            checks++;
            if (level !== LW'(mq.size())) begin
                errors++; $display("FAIL rnd_level@%0d: got %0d expected %0d", c, level, mq.size());
            end
            checks++;
            if (overflow !== mOvf) begin
                errors++; $display("FAIL rnd_ovf@%0d: got %0b expected %0b", c, overflow, mOvf);
            end
        end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] rx [$];
        int         stray = 0;
        do_reset();
        capture_en     = 1'b1;
        link.out_ready = 1'b1;
        a0             = 32'h55667788;
        tick();
        tick();
        a0 = 32'h99;
        tick();
        tick();
        checks++;
        if (link.out_valid !== 1'b1 || level !== LW'(1)) begin
            errors++; $display("FAIL mid_pre: valid=%0b level=%0d expected 1/1", link.out_valid, level);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (link.out_valid !== 1'b0 || level !== '0 || link.out_data !== 8'h00) begin
            errors++; $display("FAIL mid_async: valid=%0b level=%0d data=%0h expected 0/0/0", link.out_valid, level, link.out_data);
        end
        capture_en = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (link.out_valid) stray++;
        end
        checks++;
        if (stray != 0) begin errors++; $display("FAIL mid_stray: got %0d bytes expected 0", stray); end
        capture_en = 1'b1;
        for (int c = 0; c < NB + 6; c++) begin
            tick();
            if (link.out_valid) rx.push_back(link.out_data);
        end
        checks++;
        if (rx.size() != NB) begin
            errors++; $display("FAIL mid_refill: got %0d bytes expected %0d", rx.size(), NB);
        end else begin
            checks++;
            if (rx[TSB] !== 8'h99 || rx[TSB + 1] !== 8'h00) begin
                errors++; $display("FAIL mid_refill_data: got %0h %0h expected 99 00", rx[TSB], rx[TSB + 1]);
            end
        end
    endtask

`ifdef A0_TRACE_TIMESTAMP_EN
    task automatic test_timestamp();
        logic [7:0] expTs [8];
        int         waited = 0;
        expTs = '{8'h0A, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        do_reset();
        capture_en     = 1'b1;
        link.out_ready = 1'b1;
        while (mCnt != 32'd10 && waited < 50) begin
            tick();
            waited++;
        end
        checks++;
        if (mCnt != 32'd10) begin
            errors++; $display("FAIL ts_wait: counter %0d expected 10", mCnt);
        end else begin
            a0 = 32'hDEADBEEF;
            tick();
            tick();
            for (int k = 0; k < 8; k++) begin
                checks++;
                if (link.out_valid !== 1'b1 || link.out_data !== expTs[k]) begin
                    errors++; $display("FAIL ts_byte%0d: valid=%0b data=%0h expected 1/%0h", k, link.out_valid, link.out_data, expTs[k]);
                end
                tick();
            end
        end
    endtask
`endif

    initial begin
        link.out_ready = 1'b0;
        test_reset();
        test_single_frame();
        test_hold();
        test_overflow();
        test_backpressure();
        test_random();
        test_reset_midframe();
`ifdef A0_TRACE_TIMESTAMP_EN
        test_timestamp();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
